cv32e40x_irq_arbiter: RTL and testbench

Basic-mode (non-CLIC) interrupt front end that feeds the main controller's irq_req_ctrl/irq_id_ctrl/irq_wu_ctrl inputs.
- Synchronizes raw irq_i lines and registers them as mip.
- Masks with mie and the global enable, and arbitrates by fixed priority.
- Holds a stable request/ID towards the controller until the controller acknowledges or the source is withdrawn.

---
 rtl/cv32e40x_irq_arbiter_pkg.sv | 17 +
 rtl/cv32e40x_irq_arbiter_if.sv | 26 ++
 rtl/cv32e40x_irq_sync.sv | 31 +++
 rtl/cv32e40x_irq_arbiter.sv | 106 ++++++++++
 tb/tb_cv32e40x_irq_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cv32e40x_irq_arbiter_pkg.sv
// Shared types and constants for the basic-mode interrupt front end.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE  = 2'd0,
    IRQ_REQ   = 2'd1,
    IRQ_ACKED = 2'd2
  } irq_arb_state_e;

  // Implemented lines: MSI (3), MTI (7), MEI (11) and platform lines 16..31.
  localparam logic [31:0] IRQ_MASK_DEFAULT = 32'hFFFF_0888;

  localparam int IRQ_ID_MSI = 3;
  localparam int IRQ_ID_MTI = 7;
  localparam int IRQ_ID_MEI = 11;

endpackage

// File: rtl/cv32e40x_irq_arbiter_if.sv
// Request/ID/wakeup/acknowledge handshake between the interrupt arbiter
// and the main controller.
interface cv32e40x_irq_arbiter_if;

  logic       irq_req_ctrl;
  logic [9:0] irq_id_ctrl;
  logic       irq_wu_ctrl;
  logic       irq_ack;

  // Arbiter side: presents the request, consumes the acknowledge.
  modport master (
    output irq_req_ctrl,
    output irq_id_ctrl,
    output irq_wu_ctrl,
    input  irq_ack
  );

  // Controller side.
  modport slave (
    input  irq_req_ctrl,
    input  irq_id_ctrl,
    input  irq_wu_ctrl,
    output irq_ack
  );

endinterface

// File: rtl/cv32e40x_irq_sync.sv
// Multi-flop synchronizer for asynchronous level inputs; every stage is
// cleared by the synchronous reset.
module cv32e40x_irq_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] chain_q [SYNC_STAGES];

  // Shift the raw levels through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      chain_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/cv32e40x_irq_arbiter.sv
// Basic-mode interrupt arbiter: synchronizes irq_i into mip, masks with
// mie/mstatus.mie, picks a winner by fixed priority and holds a stable
// request/ID towards the controller until acknowledge or withdrawal.
module cv32e40x_irq_arbiter
  import cv32e40x_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] IRQ_MASK    = IRQ_MASK_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   irq_i,
  input  logic [31:0]                   mie_i,
  input  logic                          mstatus_mie_i,
  input  logic                          debug_mode_i,
  input  logic                          irq_block_i,
  output logic [31:0]                   mip_o,
  cv32e40x_irq_arbiter_if.master        ctrl
);

  // Priority 31..16, then MEI, MSI, MTI. Later assignments override
  // earlier ones, so the lowest-priority line is tested first.
  function automatic logic [4:0] prio_enc(input logic [31:0] c);
    logic [4:0] id;
    id = '0;
    if (c[IRQ_ID_MTI]) id = 5'(IRQ_ID_MTI);
    if (c[IRQ_ID_MSI]) id = 5'(IRQ_ID_MSI);
    if (c[IRQ_ID_MEI]) id = 5'(IRQ_ID_MEI);
    for (int i = 16; i < 32; i++) begin
      if (c[i]) id = 5'(i);
    end
    return id;
  endfunction

  logic [31:0]    irq_sync;
  logic [31:0]    mip_q;
  logic [31:0]    cand;
  logic [4:0]     win_id;
  logic           any_cand;
  logic           elig;
  logic           withdraw;
  irq_arb_state_e state_q;
  logic [4:0]     id_q;

  cv32e40x_irq_sync #(
    .WIDTH       (32),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (irq_i),
    .sync_o  (irq_sync)
  );

  // Pending register follows the synchronized lines every cycle, no latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      mip_q <= '0;
    end else begin
      mip_q <= irq_sync & IRQ_MASK;
    end
  end

  assign cand     = mip_q & mie_i;
  assign win_id   = prio_enc(cand);
  assign any_cand = |cand;
  assign elig     = any_cand & mstatus_mie_i & ~debug_mode_i & ~irq_block_i;
  assign withdraw = ~cand[id_q] | ~mstatus_mie_i | debug_mode_i | irq_block_i;

  // Request FSM: ID is frozen while requesting; ack outranks withdrawal.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IRQ_IDLE;
      id_q    <= '0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (elig) begin
            state_q <= IRQ_REQ;
            id_q    <= win_id;
          end
        end
        IRQ_REQ: begin
          if (ctrl.irq_ack) begin
            state_q <= IRQ_ACKED;
          end else if (withdraw) begin
            state_q <= IRQ_IDLE;
          end
        end
        IRQ_ACKED: begin
          // One quiet cycle lets the controller clear mstatus.mie.
          state_q <= IRQ_IDLE;
        end
        default: begin
          state_q <= IRQ_IDLE;
        end
      endcase
    end
  end

  assign mip_o             = mip_q;
  assign ctrl.irq_req_ctrl = (state_q == IRQ_REQ);
  assign ctrl.irq_id_ctrl  = {5'b0, id_q};
  assign ctrl.irq_wu_ctrl  = any_cand;

endmodule

// File: tb/tb_cv32e40x_irq_arbiter.sv
// Directed bench for cv32e40x_irq_arbiter: a table of steady-state vectors
// plus hand-written sequences for latency, ack and reset corner cases.
module tb_cv32e40x_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irq_i;
  logic [31:0] mie_i;
  logic        mstatus_mie_i;
  logic        debug_mode_i;
  logic        irq_block_i;
  logic [31:0] mip_o;

  int n_chk  = 0;
  int n_fail = 0;

  cv32e40x_irq_arbiter_if ctrl_if ();

  cv32e40x_irq_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .irq_i         (irq_i),
    .mie_i         (mie_i),
    .mstatus_mie_i (mstatus_mie_i),
    .debug_mode_i  (debug_mode_i),
    .irq_block_i   (irq_block_i),
    .mip_o         (mip_o),
    .ctrl          (ctrl_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] irq;
    logic [31:0] mie;
    logic        mmie;
    logic        dbg;
    logic        blk;
    logic [31:0] exp_mip;
    logic        exp_req;
    logic [9:0]  exp_id;
    logic        exp_wu;
  } vec_t;

  vec_t vecs [11];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // irq, mie, mmie, dbg, blk, exp_mip, exp_req, exp_id, exp_wu
    vecs[0]  = '{32'h0000_0800, 32'h0000_0800, 1'b1, 1'b0, 1'b0, 32'h0000_0800, 1'b1, 10'd11, 1'b1};
    vecs[1]  = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,  1'b0};
    vecs[2]  = '{32'h0001_0888, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0001_0888, 1'b1, 10'd16, 1'b1};
    vecs[3]  = '{32'h0000_0888, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0888, 1'b1, 10'd11, 1'b1};
    vecs[4]  = '{32'h0000_0088, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0088, 1'b1, 10'd3,  1'b1};
    vecs[5]  = '{32'h0000_0080, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 1'b1, 10'd7,  1'b1};
    vecs[6]  = '{32'h0000_0008, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 10'd0,  1'b1};
    vecs[7]  = '{32'h0000_0008, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 10'd0,  1'b1};
    vecs[8]  = '{32'h0000_0020, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0,  1'b0};
    vecs[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_0888, 1'b1, 10'd31, 1'b1};
    vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'hFFFF_0888, 1'b0, 10'd0,  1'b1};

    rst = 1'b1; irq_i = '0; mie_i = '0; mstatus_mie_i = 1'b0;
    debug_mode_i = 1'b0; irq_block_i = 1'b0; ctrl_if.irq_ack = 1'b0;
    tick(2);
    rst = 1'b0;

    chk("reset_mip", mip_o, 32'h0);
    chk("reset_req", 32'(ctrl_if.irq_req_ctrl), 32'h0);
    chk("reset_id",  32'(ctrl_if.irq_id_ctrl), 32'h0);
    chk("reset_wu",  32'(ctrl_if.irq_wu_ctrl), 32'h0);

    // Latency from irq_i to mip_o / req, then ack and re-request.
    irq_i = 32'h0000_0800; mie_i = 32'h0000_0800; mstatus_mie_i = 1'b1;
    tick(1);
    chk("lat_mip_k", mip_o, 32'h0);
    tick(1);
    chk("lat_mip_k1", mip_o, 32'h0);
    tick(1);
    chk("lat_mip_k2", mip_o, 32'h0000_0800);
    chk("lat_wu_k2",  32'(ctrl_if.irq_wu_ctrl), 32'h1);
    chk("lat_req_k2", 32'(ctrl_if.irq_req_ctrl), 32'h0);
    tick(1);
    chk("lat_req_k3", 32'(ctrl_if.irq_req_ctrl), 32'h1);
    chk("lat_id_k3",  32'(ctrl_if.irq_id_ctrl), 32'd11);
    ctrl_if.irq_ack = 1'b1;
    tick(1);
    ctrl_if.irq_ack = 1'b0;
    chk("ack_req_acked", 32'(ctrl_if.irq_req_ctrl), 32'h0);
    tick(1);
    chk("ack_req_idle", 32'(ctrl_if.irq_req_ctrl), 32'h0);
    tick(1);
    chk("ack_req_again", 32'(ctrl_if.irq_req_ctrl), 32'h1);

    // Steady-state vectors.
    for (int i = 0; i < 11; i++) begin
      irq_i = vecs[i].irq; mie_i = vecs[i].mie; mstatus_mie_i = vecs[i].mmie;
      debug_mode_i = vecs[i].dbg; irq_block_i = vecs[i].blk;
      tick(6);
      chk($sformatf("vec%0d_mip", i), mip_o, vecs[i].exp_mip);
      chk($sformatf("vec%0d_req", i), 32'(ctrl_if.irq_req_ctrl), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_wu", i),  32'(ctrl_if.irq_wu_ctrl), 32'(vecs[i].exp_wu));
      if (vecs[i].exp_req) begin
        chk($sformatf("vec%0d_id", i), 32'(ctrl_if.irq_id_ctrl), 32'(vecs[i].exp_id));
      end
    end

    // Frozen ID: higher-priority arrival while requesting id 7.
    irq_block_i = 1'b0; debug_mode_i = 1'b0; mstatus_mie_i = 1'b1;
    mie_i = 32'hFFFF_FFFF; irq_i = 32'h0000_0080;
    tick(6);
    chk("frz_id7", 32'(ctrl_if.irq_id_ctrl), 32'd7);
    irq_i = 32'h0000_0880;
    tick(6);
    chk("frz_req_held", 32'(ctrl_if.irq_req_ctrl), 32'h1);
    chk("frz_id_held", 32'(ctrl_if.irq_id_ctrl), 32'd7);
    irq_i = 32'h0000_0800;
    tick(6);
    chk("frz_req_next", 32'(ctrl_if.irq_req_ctrl), 32'h1);
    chk("frz_id_next", 32'(ctrl_if.irq_id_ctrl), 32'd11);

    // Ack and block together: ack wins, so two quiet cycles before re-request.
    irq_block_i = 1'b1; ctrl_if.irq_ack = 1'b1;
    tick(1);
    irq_block_i = 1'b0; ctrl_if.irq_ack = 1'b0;
    chk("ackblk_req0", 32'(ctrl_if.irq_req_ctrl), 32'h0);
    tick(1);
    chk("ackblk_req1", 32'(ctrl_if.irq_req_ctrl), 32'h0);
    tick(1);
    chk("ackblk_req2", 32'(ctrl_if.irq_req_ctrl), 32'h1);

    // Block alone: withdrawal to IDLE, re-request right after.
    irq_block_i = 1'b1;
    tick(1);
    irq_block_i = 1'b0;
    chk("blk_req0", 32'(ctrl_if.irq_req_ctrl), 32'h0);
    tick(1);
    chk("blk_req1", 32'(ctrl_if.irq_req_ctrl), 32'h1);

    // Reset during REQ with ack high, then full resync latency.
    rst = 1'b1; ctrl_if.irq_ack = 1'b1;
    tick(1);
    rst = 1'b0; ctrl_if.irq_ack = 1'b0;
    chk("rst_mip", mip_o, 32'h0);
    chk("rst_req", 32'(ctrl_if.irq_req_ctrl), 32'h0);
    chk("rst_id",  32'(ctrl_if.irq_id_ctrl), 32'h0);
    chk("rst_wu",  32'(ctrl_if.irq_wu_ctrl), 32'h0);
    begin
      int cnt;
      cnt = 0;
      while (ctrl_if.irq_req_ctrl !== 1'b1 && cnt < 20) begin
        tick(1);
        cnt++;
      end
      chk("rst_relatency", 32'(cnt), 32'd4);
      chk("rst_id_after", 32'(ctrl_if.irq_id_ctrl), 32'd11);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
